// File: rtl/bit_deserializer.sv
// Serial-to-parallel deserializer: hunts for SYNC_PAT, then shifts in W bits MSB first into a valid/ready holding register.
// Optional even-parity bit after each word when BIT_DESERIALIZER_PARITY_EN is defined.
module bit_deserializer #(
  parameter int         W        = 8,
  parameter logic [3:0] SYNC_PAT = 4'b1101
) (
  input  logic         c,
  input  logic         rn,
  input  logic         d,
  input  logic         en,
  input  logic         rdy,
  output logic [W-1:0] q,
  output logic         v,
  output logic         busy,
  output logic         ovf,
  output logic         perr
);

  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] S_HUNT = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
`ifdef BIT_DESERIALIZER_PARITY_EN
  localparam logic [1:0] S_PAR  = 2'd2;

  function automatic logic even_par_ok(input logic [W-1:0] w, input logic p);
    return ~(^w ^ p);
  endfunction
`endif

  logic [1:0]    state_q, state_d;
  logic [3:0]    win_q, win_d, win_nx_s;
  logic [W-1:0]  shift_q, shift_d, shift_nx_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  word_q, word_d, cword_s;
  logic          v_q, v_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;
  logic          perr_q, perr_d;
  logic          commit_s;

  // Frame FSM: sync hunt, data shift and optional parity check.
  always_comb begin
    win_nx_s   = {win_q[2:0], d};
    shift_nx_s = {shift_q[W-2:0], d};
    state_d    = state_q;
    win_d      = win_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    commit_s   = 1'b0;
    cword_s    = shift_nx_s;
    perr_d     = 1'b0;
    case (state_q)
      S_HUNT: begin
        if (en) begin
          if (win_nx_s == SYNC_PAT) begin
            state_d = S_DATA;
            cnt_d   = {CW{1'b0}};
            win_d   = 4'b0000;
          end else begin
            win_d   = win_nx_s;
          end
        end else begin
          win_d = win_q;
        end
      end
      S_DATA: begin
        if (en) begin
          shift_d = shift_nx_s;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) begin
`ifdef BIT_DESERIALIZER_PARITY_EN
            state_d  = S_PAR;
`else
            state_d  = S_HUNT;
            commit_s = 1'b1;
`endif
          end else begin
            state_d = S_DATA;
          end
        end else begin
          shift_d = shift_q;
        end
      end
`ifdef BIT_DESERIALIZER_PARITY_EN
      S_PAR: begin
        if (en) begin
          state_d = S_HUNT;
          cword_s = shift_q;
          if (even_par_ok(shift_q, d)) begin
            commit_s = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
        end else begin
          state_d = S_PAR;
        end
      end
`endif
      default: begin
        state_d = S_HUNT;
      end
    endcase
  end

  // Output holding register: a commit may coincide with a transfer; otherwise a full register drops the word.
  always_comb begin
    word_d = word_q;
    v_d    = v_q;
    ovf_d  = ovf_q;
    busy_d = (state_d != S_HUNT);
    if (commit_s) begin
      if (!v_q || rdy) begin
        word_d = cword_s;
        v_d    = 1'b1;
      end else begin
        ovf_d  = 1'b1;
      end
    end else if (v_q && rdy) begin
      v_d = 1'b0;
    end else begin
      v_d = v_q;
    end
  end

  // State and output registers.
  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      state_q <= S_HUNT;
      win_q   <= 4'b0000;
      shift_q <= {W{1'b0}};
      cnt_q   <= {CW{1'b0}};
      word_q  <= {W{1'b0}};
      v_q     <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      v_q     <= v_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      perr_q  <= perr_d;
    end
  end

  assign q    = word_q;
  assign v    = v_q;
  assign busy = busy_q;
  assign ovf  = ovf_q;
  assign perr = perr_q;

endmodule

// File: tb/tb_bit_deserializer.sv
// Directed bench for bit_deserializer; expected words flow through a scoreboard queue.
module tb_bit_deserializer;
  localparam int W = 8;

  logic         c = 1'b0;
  logic         rn;
  logic         d;
  logic         en;
  logic         rdy;
  logic [W-1:0] q;
  logic         v;
  logic         busy;
  logic         ovf;
  logic         perr;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W+4:0] fr;
  int           lo;

  bit_deserializer #(.W(W), .SYNC_PAT(4'b1101)) dut (
    .c(c), .rn(rn), .d(d), .en(en), .rdy(rdy),
    .q(q), .v(v), .busy(busy), .ovf(ovf), .perr(perr)
  );

  always #5 c = ~c;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic dv, input logic ev);
    d  = dv;
    en = ev;
    @(posedge c);
    #1;
  endtask

  task automatic send_sync;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
  endtask

  // Last edge of the frame (data or parity) sees rdy = last_rdy.
  task automatic send_word(input logic [W-1:0] w, input logic last_rdy);
    for (int i = W - 1; i >= 0; i--) begin
`ifndef BIT_DESERIALIZER_PARITY_EN
      if (i == 0) rdy = last_rdy;
`endif
      step(w[i], 1'b1);
    end
`ifdef BIT_DESERIALIZER_PARITY_EN
    rdy = last_rdy;
    step(^w, 1'b1);
`endif
    rdy = 1'b0;
  endtask

  task automatic check_word(input string tag);
    check({tag, "_v"}, {31'd0, v}, 32'd1);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s_q: observed %0h expected (scoreboard empty)", tag, q);
    end else begin
      check({tag, "_q"}, {24'd0, q}, {24'd0, exp_q[0]});
    end
  endtask

  task automatic consume(input string tag);
    rdy = 1'b1;
    step(1'b0, 1'b0);
    rdy = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    check({tag, "_v_clr"}, {31'd0, v}, 32'd0);
  endtask

  initial begin
    rn  = 1'b0;
    d   = 1'b0;
    en  = 1'b0;
    rdy = 1'b0;
    #12;
    check("rst_q",    {24'd0, q},    32'd0);
    check("rst_v",    {31'd0, v},    32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovf",  {31'd0, ovf},  32'd0);
    check("rst_perr", {31'd0, perr}, 32'd0);
    rn = 1'b1;
    @(posedge c);
    #1;

    // Fill the holding register, then drop a second word.
    send_sync;
    send_word(8'hA5, 1'b0);
    exp_q.push_back(8'hA5);
    check_word("fill");
    send_sync;
    send_word(8'h3C, 1'b0);
    check("ovf_set", {31'd0, ovf}, 32'd1);
    check_word("ovf_keep");

    // Asynchronous reset in the middle of a frame.
    send_sync;
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check("mid_busy", {31'd0, busy}, 32'd1);
    #2 rn = 1'b0;
    #1;
    check("arst_q",    {24'd0, q},    32'd0);
    check("arst_v",    {31'd0, v},    32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_ovf",  {31'd0, ovf},  32'd0);
    exp_q.delete();
    #1 rn = 1'b1;
    @(posedge c);
    #1;

    // Basic frame.
    send_sync;
    check("basic_busy", {31'd0, busy}, 32'd1);
    send_word(8'hA5, 1'b0);
    exp_q.push_back(8'hA5);
    check("basic_idle", {31'd0, busy}, 32'd0);
    check_word("basic");
    consume("basic");
    check("basic_hold", {24'd0, q}, 32'h0000_00A5);

    // Bit strobe gating with random data on idle edges.
    fr = {4'b1101, 8'hA5, ^8'hA5};
`ifdef BIT_DESERIALIZER_PARITY_EN
    lo = 0;
`else
    lo = 1;
`endif
    for (int i = W + 4; i >= lo; i--) begin
      step(fr[i], 1'b1);
      step(1'($urandom_range(0, 1)), 1'b0);
    end
    exp_q.push_back(8'hA5);
    check_word("engate");
    consume("engate");

    // False sync: only the second 1101 locks.
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("fsync_hunt", {31'd0, busy}, 32'd0);
    send_sync;
    check("fsync_lock", {31'd0, busy}, 32'd1);
    send_word(8'h3C, 1'b0);
    exp_q.push_back(8'h3C);
    check_word("fsync");
    consume("fsync");

    // Back-to-back with a transfer on the completion edge.
    send_sync;
    send_word(8'hA5, 1'b0);
    exp_q.push_back(8'hA5);
    check_word("b2b_first");
    send_sync;
    send_word(8'h3C, 1'b1);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h3C);
    check_word("b2b_second");
    check("b2b_ovf", {31'd0, ovf}, 32'd0);
    consume("b2b");
    check("perr_idle", {31'd0, perr}, 32'd0);

`ifdef BIT_DESERIALIZER_PARITY_EN
    // Bad parity: discard with a single-cycle error pulse.
    send_sync;
    for (int i = W - 1; i >= 0; i--) step(fr[i + 1], 1'b1);
    step(~(^8'hA5), 1'b1);
    check("par_perr", {31'd0, perr}, 32'd1);
    check("par_v",    {31'd0, v},    32'd0);
    check("par_q",    {24'd0, q},    32'h0000_003C);
    check("par_ovf",  {31'd0, ovf},  32'd0);
    step(1'b0, 1'b0);
    check("par_pulse", {31'd0, perr}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
